quet_led_7doan: RTL and testbench
=================================

// Module: quet_led_7doan
// PURPOSE
//   Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
//   Holds one hex nibble per digit and drives one shared hex-to-segment decoder (gm_led_7doan).
//   Enables one digit at a time, with a dead-time (blanking) gap between digits to stop ghosting.
//   Sits between the user datapath (counters, registers) and the board's anode/segment pins.
// PARAMETERS
//   N_DIGIT     4      number of digits; legal range 1..8
//   REFRESH_DIV 50000  clk cycles per digit slot (blank + show); must be > BLANK_CYC
//   BLANK_CYC   16     cycles at the start of each slot with all anodes off; must be >= 1
// PORTS
//   clk      in   1          system clock, single clock domain
//   reset    in   1          asynchronous, active-high reset
//   enable   in   1          1 = scanning; 0 = display dark
//   load     in   1          1-cycle strobe: capture data_in/dp_in into the pending register
//   data_in  in   4*N_DIGIT  nibble k = digit k (digit 0 = rightmost)
//   dp_in    in   N_DIGIT    decimal point per digit, 1 = lit
//   blank_lz in   1          1 = suppress leading zeros
//   load_ack out  1          1-cycle pulse: pending data committed to the display
//   an       out  N_DIGIT    anodes, active-low
//   sseg     out  7          segments {g..a}, active-low
//   dp       out  1          decimal point, active-low
// BEHAVIOUR
//   - Reset (async, immediate):
//     - outputs: an = all 1s, sseg = 7'h7F, dp = 1, load_ack = 0.
//     - internal: idx = 0, slot counter = 0; active and pending registers = 0; state = IDLE.
//   - State machine: IDLE, BLANK, SHOW.
//     - IDLE: outputs dark. When enable = 1, go to BLANK with idx = 0 and do a commit (see below).
//     - BLANK: all anodes off for BLANK_CYC cycles, then go to SHOW.
//     - SHOW: an[idx] = 0 for REFRESH_DIV - BLANK_CYC cycles, then go to BLANK with idx+1.
//     - idx wraps from N_DIGIT-1 to 0; every wrap does a commit.
//   - enable = 0 in any state: IDLE on the next clock. Re-enabling always restarts at digit 0.
//   - Outputs are registered and lag the state/idx by exactly 1 clk.
//     sseg = decode(active nibble[idx]); dp = ~active_dp[idx].
//   - load: pending <= {data_in, dp_in}. Back-to-back loads overwrite; only the last one counts.
//   - Commit: active <= pending, and load_ack pulses on the next cycle.
//     - A commit happens only if a load arrived since the previous commit.
//     - If load coincides with the commit cycle, the data_in of that cycle is committed (bypass).
//     - The display never shows a mix of old and new digits within one frame.
//   - Leading-zero blanking (blank_lz = 1):
//     - digit k >= 1 shows sseg = 7'h7F if its nibble and all higher nibbles are 0.
//     - digit 0 is never blanked.
//     - dp follows dp_in regardless of blanking.
//   - Slot counter width is $clog2(REFRESH_DIV); it restarts at 0 on every state entry.
//   - N_DIGIT = 1: idx stays 0, and every slot end is a wrap.
// STRUCTURE
//   - Shared header led7_defs.vh holds:
//     - SSEG_OFF = 7'h7F, AN_OFF (all 1s)
//     - state encodings IDLE/BLANK/SHOW
//   - One sub-module: gm_led_7doan, a single instance fed by the selected active nibble.
//   - Scan FSM, counter, pending/active registers and blanking logic live in this module.
// TESTING (N_DIGIT=4, REFRESH_DIV=8, BLANK_CYC=2)
//   1. Reset mid-SHOW -> an = 4'hF, sseg = 7'h7F, dp = 1 before the next clk edge; load_ack = 0.
//   2. load 16'h12A0, enable = 1 -> load_ack pulses once. After each 2-cycle all-off gap:
//      an 1110 sseg 1000000, an 1101 0001000, an 1011 0100100, an 0111 1111001. Each slot 8 cycles.
//   3. blank_lz = 1, data 16'h0050 -> digits 3 and 2 show 7'h7F, digit 1 shows 0010010,
//      digit 0 shows 1000000.
//   4. load 16'h9999 while idx = 2 -> digits 2 and 3 still show old data;
//      new data appears from digit 0 after the wrap; exactly one load_ack.
//   5. load on the exact wrap cycle -> that cycle's data is shown at digit 0, not the previous pending.
//   6. enable drops mid-SHOW at idx = 2 -> dark on the next clk;
//      after re-enable, the first lit anode is 1110 after BLANK_CYC cycles.

Source files
------------

// File: rtl/quet_led_7doan_pkg.sv
// Shared definitions for the 7-segment scan controller: dark levels, scan
// states and the active-low hex-to-segment table.
package quet_led_7doan_pkg;

  localparam logic [6:0] SSEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  // Segment order {g,f,e,d,c,b,a}, 0 = segment lit.
  function automatic logic [6:0] hex2sseg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/quet_led_7doan_gm.sv
// Shared hex-to-segment decoder for the scanned display (active-low outputs).
module gm_led_7doan
  import quet_led_7doan_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] sseg_o
);

  assign sseg_o = hex2sseg(nibble_i);

endmodule

// File: rtl/quet_led_7doan.sv
// Time-multiplexed N-digit common-anode 7-segment scan controller with
// blanking gaps, frame-aligned data commit and optional leading-zero blanking.
module quet_led_7doan
  import quet_led_7doan_pkg::*;
#(
  parameter int N_DIGIT     = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   load,
  input  logic [4*N_DIGIT-1:0]   data_in,
  input  logic [N_DIGIT-1:0]     dp_in,
  input  logic                   blank_lz,
  output logic                   load_ack,
  output logic [N_DIGIT-1:0]     an,
  output logic [6:0]             sseg,
  output logic                   dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (N_DIGIT > 1) ? $clog2(N_DIGIT) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGIT - 1);

  scan_state_e            state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [4*N_DIGIT-1:0]   pend_q, act_q;
  logic [N_DIGIT-1:0]     pend_dp_q, act_dp_q;
  logic                   pend_vld_q;
  logic                   commit_ev, commit;
  logic [N_DIGIT-1:0]     an_q;
  logic [6:0]             sseg_q;
  logic                   dp_q, ack_q;

  logic [N_DIGIT-1:0]     lz;
  logic                   higher_zero;
  logic [3:0]             sel_nib;
  logic                   sel_dp, sel_lz;
  logic [6:0]             dec_sseg;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + CNT_W'(1);
    commit_ev = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = BLANK;
          idx_d     = '0;
          cnt_d     = '0;
          commit_ev = 1'b1;
        end
        BLANK: if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end
        SHOW: if (cnt_q == SHOW_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d     = '0;
            commit_ev = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A load landing in the commit cycle itself is forwarded straight to active.
  assign commit = commit_ev && (pend_vld_q || load);

  always_comb begin
    lz          = '0;
    higher_zero = 1'b1;
    for (int k = N_DIGIT - 1; k >= 0; k--) begin
      higher_zero = higher_zero && (act_q[k*4 +: 4] == 4'h0);
      lz[k]       = higher_zero && (k != 0);
    end
  end

  always_comb begin
    sel_nib = '0;
    sel_dp  = 1'b0;
    sel_lz  = 1'b0;
    for (int k = 0; k < N_DIGIT; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_nib = act_q[k*4 +: 4];
        sel_dp  = act_dp_q[k];
        sel_lz  = lz[k];
      end
    end
  end

  gm_led_7doan u_dec (
    .nibble_i (sel_nib),
    .sseg_o   (dec_sseg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      act_q      <= '0;
      act_dp_q   <= '0;
      an_q       <= '1;
      sseg_q     <= SSEG_OFF;
      dp_q       <= 1'b1;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      ack_q      <= commit;
      pend_vld_q <= commit ? 1'b0 : (pend_vld_q | load);
      if (load) begin
        pend_q    <= data_in;
        pend_dp_q <= dp_in;
      end
      if (commit) begin
        act_q    <= load ? data_in : pend_q;
        act_dp_q <= load ? dp_in : pend_dp_q;
      end
      // Dropping enable darkens the pins on the very next edge.
      if (enable && state_q == SHOW) begin
        an_q   <= ~(N_DIGIT'(1) << idx_q);
        sseg_q <= (blank_lz && sel_lz) ? SSEG_OFF : dec_sseg;
        dp_q   <= ~sel_dp;
      end else begin
        an_q   <= '1;
        sseg_q <= SSEG_OFF;
        dp_q   <= 1'b1;
      end
    end
  end

  assign an       = an_q;
  assign sseg     = sseg_q;
  assign dp       = dp_q;
  assign load_ack = ack_q;

endmodule

// File: tb/tb_quet_led_7doan.sv
// Directed bench for quet_led_7doan with a 4-digit, 8-cycle-slot, 2-cycle-gap setup.
module tb_quet_led_7doan;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load_ack;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic        dp;

  int n_vec = 0;
  int n_err = 0;
  int ack_cnt = 0;

  quet_led_7doan #(
    .N_DIGIT     (4),
    .REFRESH_DIV (8),
    .BLANK_CYC   (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .load     (load),
    .data_in  (data_in),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .load_ack (load_ack),
    .an       (an),
    .sseg     (sseg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (load_ack === 1'b1) ack_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One digit slot: two dark samples, then up to six lit samples.
  // A one-cycle load pulse is driven after sample ldpos (-1 = none).
  task automatic slot(input int k, input logic [6:0] seg, input logic dpo, input int nsamp,
                      input int ldpos, input logic [15:0] ld_d, input logic [3:0] ld_dp);
    logic [3:0] an_exp;
    an_exp = ~(4'b0001 << k);
    for (int j = 0; j < nsamp; j++) begin
      step();
      if (j < 2)
        chk($sformatf("d%0d gap%0d", k, j), {20'h0, an, sseg, dp}, {20'h0, 4'hF, 7'h7F, 1'b1});
      else
        chk($sformatf("d%0d lit%0d", k, j), {20'h0, an, sseg, dp}, {20'h0, an_exp, seg, dpo});
      load = (j == ldpos);
      if (j == ldpos) begin
        data_in = ld_d;
        dp_in   = ld_dp;
      end
    end
  endtask

  task automatic frame(input logic [27:0] segs, input logic [3:0] dpin);
    for (int k = 0; k < 4; k++) slot(k, segs[k*7 +: 7], ~dpin[k], 8, -1, 16'h0, 4'h0);
  endtask

  task automatic chk_dark(input string tag);
    chk(tag, {20'h0, an, sseg, dp}, {20'h0, 4'hF, 7'h7F, 1'b1});
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk_dark("reset out");
    chk("reset ack", {31'h0, load_ack}, 32'h0);
    step();
    step();
    reset = 1'b0;

    // Basic scan of 12A0 with a decimal point on digit 2.
    load = 1'b1; data_in = 16'h12A0; dp_in = 4'b0100;
    step();
    load = 1'b0; enable = 1'b1;
    step();
    chk_dark("enable lag");
    frame({7'h79, 7'h24, 7'h08, 7'h40}, 4'b0100);
    chk("ack F1", ack_cnt, 1);

    // Load mid-frame at digit 2: the rest of this frame keeps old data.
    slot(0, 7'h40, 1'b1, 8, -1, 16'h0, 4'h0);
    slot(1, 7'h08, 1'b1, 8, -1, 16'h0, 4'h0);
    slot(2, 7'h24, 1'b0, 8, 3, 16'h9999, 4'h0);
    slot(3, 7'h79, 1'b1, 8, -1, 16'h0, 4'h0);
    chk("ack F2", ack_cnt, 1);

    // New frame shows 9999; a load on the wrap cycle itself wins over pending 3333.
    slot(0, 7'h10, 1'b1, 8, -1, 16'h0, 4'h0);
    slot(1, 7'h10, 1'b1, 8, 2, 16'h3333, 4'hF);
    slot(2, 7'h10, 1'b1, 8, -1, 16'h0, 4'h0);
    slot(3, 7'h10, 1'b1, 8, 6, 16'h0050, 4'b1000);
    chk("ack F3", ack_cnt, 2);

    // Leading-zero blanking of 0050; dp on digit 3 stays lit while blanked.
    blank_lz = 1'b1;
    frame({7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1000);
    chk("ack F4", ack_cnt, 3);

    // Enable drops mid-SHOW at digit 2.
    slot(0, 7'h40, 1'b1, 8, -1, 16'h0, 4'h0);
    slot(1, 7'h12, 1'b1, 8, -1, 16'h0, 4'h0);
    slot(2, 7'h7F, 1'b1, 5, -1, 16'h0, 4'h0);
    enable = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      chk_dark($sformatf("disabled%0d", j));
    end
    chk("ack F5", ack_cnt, 3);

    // Re-enable restarts at digit 0 without a new commit.
    blank_lz = 1'b0;
    enable = 1'b1;
    step();
    chk_dark("reenable lag");
    frame({7'h40, 7'h40, 7'h12, 7'h40}, 4'b1000);
    chk("ack F6", ack_cnt, 3);

    // Asynchronous reset in the middle of a lit slot.
    slot(0, 7'h40, 1'b1, 5, -1, 16'h0, 4'h0);
    #2 reset = 1'b1;
    enable = 1'b0;
    #1;
    chk_dark("async reset out");
    chk("async reset ack", {31'h0, load_ack}, 32'h0);
    step();
    step();
    reset = 1'b0;
    enable = 1'b1;
    step();
    chk_dark("post reset lag");
    frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000);
    chk("ack end", ack_cnt, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
